conv_ctrl: RTL and testbench
============================

Name: conv_ctrl

Overview:
Sequencer for the 3x3 convolution datapath.
- Loads KERNEL_SIZE^2 coefficients into kernel_mem.
- Streams a raster-order image into the line shift register.
- Enables the multiplier only when a full valid window is present.
- Returns each result to the host over a valid/ready handshake with backpressure.
- Sits between the Wishbone/host-side FIFO and the kernel_mem, shift_register and multiplier instances inside the convolve top level.

Parameters:
BITS, 9, pixel/coefficient width (signed)
KERNEL_SIZE, 3, kernel edge length
IMG_W, 32, image width in pixels (>= KERNEL_SIZE)
IMG_H, 32, image height in pixels (>= KERNEL_SIZE)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a frame; sampled only in IDLE
reuse_kernel  in  1  sampled with start; 1 = skip kernel load
k_valid  in  1  host coefficient valid
k_ready  out  1  controller accepts coefficient
kernel_write_en  out  1  write strobe to kernel_mem (= k_valid & k_ready)
pix_valid  in  1  host pixel valid
pix_ready  out  1  controller accepts pixel
shift_write_en  out  1  shift strobe to shift_register (= pix_valid & pix_ready)
out_en  out  1  multiplier enable, one cycle per valid window
mult_result  in  BITS  multiplier pixel_out (registered in multiplier)
res_valid  out  1  result available
res_data  out  BITS  result value
res_ready  in  1  host consumes result
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Async reset (reset_n=0): state IDLE; all counters 0; every output 0, including res_data.
- FSM states: IDLE, LOAD_K, STREAM, DRAIN, DONE.
- IDLE:
  - start=1, reuse_kernel=0 -> LOAD_K.
  - start=1, reuse_kernel=1 -> STREAM.
  - row/col/k_cnt cleared on the start cycle.
- LOAD_K:
  - k_ready=1.
  - Each handshake increments k_cnt.
  - On the KERNEL_SIZE^2-th handshake -> STREAM next cycle.
- STREAM: pix_ready = !(res_valid & !res_ready) & !pend.
  - Each accepted pixel advances col.
  - col wraps at IMG_W-1 to 0 and increments row.
- Window valid when the accepted pixel has row >= KERNEL_SIZE-1 and col >= KERNEL_SIZE-1. No padding.
- Timing for a valid window:
  - Pixel accepted at cycle t -> out_en=1 in cycle t+1; pend=1 during t+1.
  - res_valid=1 and res_data=mult_result from cycle t+2.
  - Both hold until res_valid & res_ready.
- Throughput:
  - res_ready=1 on every cycle: pix_ready toggles 1/0.
  - Pend is cleared when the result is captured.
- Results per frame: (IMG_W-KERNEL_SIZE+1)*(IMG_H-KERNEL_SIZE+1). Raster order, no gaps, no duplicates.
- Acceptance of pixel (IMG_H-1, IMG_W-1) -> DRAIN.
- DRAIN: pix_ready=0; wait until the final result handshake completes -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- start outside IDLE is ignored.
- k_valid outside LOAD_K and pix_valid outside STREAM are ignored: no strobes, no counter changes.
- Simultaneous res_valid & res_ready and new pixel acceptance in the same cycle is legal: the result is consumed and pix_ready may be 1 that cycle.
- reset_n asserted mid-frame -> immediate IDLE; any pending result is discarded.
- Counter widths: clog2(IMG_W), clog2(IMG_H), clog2(KERNEL_SIZE^2+1).

Optional Feature:
Macro CONV_CTRL_PERF_EN.
- Defined:
  - Adds output port stall_cycles [15:0].
  - Counts STREAM cycles with pix_valid=1 & pix_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared on accepted start and on reset; holds its value after DONE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- IMG_W=5, IMG_H=4. start, reuse_kernel=0; feed coefficients 1..9 -> kernel_write_en pulses exactly 9 times, k_ready drops after the 9th, state STREAM.
- Same config; stream pixels 0..19 with res_ready=1 -> exactly 6 out_en pulses. Pulses follow pixels 12,13,14,17,18,19. Six res_valid handshakes; done pulse once; busy returns 0.
- Hold res_ready=0 after the first result -> res_valid and res_data stable; pix_ready=0; no further shift_write_en until res_ready=1.
- Second frame with reuse_kernel=1 -> no k_ready/kernel_write_en activity; STREAM entered the cycle after start.
- Drop reset_n at pixel 10 -> all outputs 0 immediately. A fresh start then produces a full 6-result frame.
- With CONV_CTRL_PERF_EN and pix_valid held at 1, res_ready=1 -> stall_cycles = 5 at DONE (one per interleaved pend cycle). Cleared to 0 on the next start.

Source files
------------

// File: rtl/conv_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv_ctrl_if
// Handshake bundle between the host side (coefficient/pixel FIFO, result
// consumer, multiplier result) and the convolution sequencer conv_ctrl.
//
// Signals:
//   k_valid / k_ready / kernel_write_en   coefficient load handshake + strobe
//   pix_valid / pix_ready / shift_write_en pixel stream handshake + strobe
//   out_en                                 multiplier enable (one per window)
//   mult_result                            registered multiplier output
//   res_valid / res_data / res_ready       result return handshake
//
// Modports:
//   master  host / surrounding datapath view
//   slave   controller view (used by conv_ctrl)
// ---------------------------------------------------------------------------
interface conv_ctrl_if #(
  parameter int BITS = 9
);
  logic                   k_valid;
  logic                   k_ready;
  logic                   kernel_write_en;
  logic                   pix_valid;
  logic                   pix_ready;
  logic                   shift_write_en;
  logic                   out_en;
  logic signed [BITS-1:0] mult_result;
  logic                   res_valid;
  logic signed [BITS-1:0] res_data;
  logic                   res_ready;

  modport master (
    output k_valid,
    input  k_ready,
    input  kernel_write_en,
    output pix_valid,
    input  pix_ready,
    input  shift_write_en,
    input  out_en,
    output mult_result,
    input  res_valid,
    input  res_data,
    output res_ready
  );

  modport slave (
    input  k_valid,
    output k_ready,
    output kernel_write_en,
    input  pix_valid,
    output pix_ready,
    output shift_write_en,
    output out_en,
    input  mult_result,
    output res_valid,
    output res_data,
    input  res_ready
  );
endinterface

// File: rtl/conv_ctrl.sv
// ---------------------------------------------------------------------------
// conv_ctrl
// Sequencer for the KERNEL_SIZE x KERNEL_SIZE convolution datapath. Loads the
// kernel coefficients, streams a raster-order image into the line shift
// register, fires the multiplier once per fully valid window (no padding)
// and returns each result to the host over a valid/ready handshake.
//
// Ports:
//   clk             clock
//   reset_n         asynchronous active-low reset
//   i_start         begin a frame (sampled only in IDLE)
//   i_reuse_kernel  sampled with i_start; 1 = skip the kernel load
//   bus             conv_ctrl_if.slave handshake bundle
//   o_busy          controller not idle
//   o_done          one-cycle pulse at frame end
//   o_stall_cycles  (only with CONV_CTRL_PERF_EN) saturating count of STREAM
//                   cycles where a pixel was offered but not accepted
//
// Optional feature macro: CONV_CTRL_PERF_EN
// ---------------------------------------------------------------------------
module conv_ctrl #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic         i_reuse_kernel,
  conv_ctrl_if.slave   bus,
  output logic         o_busy,
  output logic         o_done
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [15:0]  o_stall_cycles
`endif
);

  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int KCNT_W = $clog2(KK + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_K = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [COL_W-1:0]       r_col;
  logic [ROW_W-1:0]       r_row;
  logic [KCNT_W-1:0]      r_kcnt;
  logic                   r_k_ready;
  logic                   r_out_en;
  logic                   r_res_valid;
  logic signed [BITS-1:0] r_res_data;
  logic                   r_busy;
  logic                   r_done;

  logic w_res_stall;
  logic w_pix_ready;
  logic w_pix_acc;
  logic w_k_acc;
  logic w_window;
  logic w_last_pix;
  logic w_last_col;
  logic w_res_hs;

  // A result still waiting for the host blocks new pixels; r_out_en doubles
  // as the "pend" flag: the window's result is in flight to r_res_data.
  assign w_res_stall = r_res_valid & ~bus.res_ready;
  assign w_pix_ready = (r_state == STREAM) & ~w_res_stall & ~r_out_en;
  assign w_pix_acc   = bus.pix_valid & w_pix_ready;
  assign w_k_acc     = bus.k_valid & r_k_ready;
  assign w_res_hs    = r_res_valid & bus.res_ready;

  assign w_window   = (r_row >= ROW_W'(KERNEL_SIZE - 1)) &&
                      (r_col >= COL_W'(KERNEL_SIZE - 1));
  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_last_pix = w_last_col && (r_row == ROW_W'(IMG_H - 1));

  assign bus.k_ready         = r_k_ready;
  assign bus.kernel_write_en = w_k_acc;
  assign bus.pix_ready       = w_pix_ready;
  assign bus.shift_write_en  = w_pix_acc;
  assign bus.out_en          = r_out_en;
  assign bus.res_valid       = r_res_valid;
  assign bus.res_data        = r_res_data;
  assign o_busy              = r_busy;
  assign o_done              = r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_kcnt      <= '0;
      r_k_ready   <= 1'b0;
      r_out_en    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      // w_pix_acc can only be high in STREAM, so this is quiet elsewhere.
      r_out_en <= w_pix_acc & w_window;

      // The multiplier output is captured in the pend cycle; a held result
      // can never coincide with pend because acceptance needed it consumed.
      if (r_out_en) begin
        r_res_valid <= 1'b1;
        r_res_data  <= bus.mult_result;
      end else if (w_res_hs) begin
        r_res_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_col  <= '0;
            r_row  <= '0;
            r_kcnt <= '0;
            r_busy <= 1'b1;
            if (i_reuse_kernel) begin
              r_state <= STREAM;
            end else begin
              r_state   <= LOAD_K;
              r_k_ready <= 1'b1;
            end
          end
        end
        LOAD_K: begin
          if (w_k_acc) begin
            r_kcnt <= r_kcnt + 1'b1;
            if (r_kcnt == KCNT_W'(KK - 1)) begin
              r_state   <= STREAM;
              r_k_ready <= 1'b0;
            end
          end
        end
        STREAM: begin
          if (w_pix_acc) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= w_last_pix ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_last_pix) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Leave only once the last window is captured and handed over.
          if (!r_out_en && (!r_res_valid || bus.res_ready)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_k_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_CTRL_PERF_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if ((r_state == IDLE) && i_start) begin
      r_stall <= '0;
    end else if ((r_state == STREAM) && bus.pix_valid && !w_pix_ready &&
                 (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign o_stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
`timescale 1ns/1ps
module tb_conv_ctrl;
  localparam int BITS = 9;
  localparam int KS   = 3;
  localparam int W    = 5;
  localparam int H    = 4;
  localparam int NRES = (W - KS + 1) * (H - KS + 1);

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic reuse   = 1'b0;
  logic busy;
  logic done;
`ifdef CONV_CTRL_PERF_EN
  logic [15:0] stall_cycles;
`endif

  conv_ctrl_if #(.BITS(BITS)) bus ();

  conv_ctrl #(
    .BITS(BITS), .KERNEL_SIZE(KS), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_start(start),
    .i_reuse_kernel(reuse),
    .bus(bus),
    .o_busy(busy),
    .o_done(done)
`ifdef CONV_CTRL_PERF_EN
    ,
    .o_stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Value the bench multiplier presents for the window closed by pixel i.
  function automatic logic [BITS-1:0] tag(input int i);
    return BITS'(i * 23 - 200);
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum int {P_IDLE, P_LOAD, P_STREAM, P_DRAIN, P_DONE} ph_t;
  ph_t            ph = P_IDLE;
  int             pidx = 0, kcnt = 0, m_stall = 0, m_out_idx = 0;
  logic           m_out_en = 1'b0, m_res_valid = 1'b0;
  logic [BITS-1:0] m_res_data = '0, m_tag = '0, nxt_mult = '0;
  int             kw_cnt = 0, res_cnt = 0;
  int             out_idx_q[$];
  bit             done_seen = 1'b0;

  always @(negedge clk) begin : cmp
    logic mk, mp, acc_k, acc_p, n_out, drain_ok;
    if (!reset_n) begin
      ph = P_IDLE; pidx = 0; kcnt = 0; m_stall = 0;
      m_out_en = 1'b0; m_res_valid = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_k_ready", bus.k_ready, 0);
      chk("rst_pix_ready", bus.pix_ready, 0);
      chk("rst_out_en", bus.out_en, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_data", bus.res_data, 0);
    end else begin
      mk = (ph == P_LOAD);
      mp = (ph == P_STREAM) && !(m_res_valid && !bus.res_ready) && !m_out_en;
      chk("k_ready", bus.k_ready, mk);
      chk("pix_ready", bus.pix_ready, mp);
      chk("kernel_write_en", bus.kernel_write_en, bus.k_valid && mk);
      chk("shift_write_en", bus.shift_write_en, bus.pix_valid && mp);
      chk("out_en", bus.out_en, m_out_en);
      chk("res_valid", bus.res_valid, m_res_valid);
      if (m_res_valid) chk("res_data", bus.res_data, m_res_data);
      chk("busy", busy, ph != P_IDLE);
      chk("done", done, ph == P_DONE);
`ifdef CONV_CTRL_PERF_EN
      chk("stall_cycles", stall_cycles, 32'(m_stall));
`endif
      if (bus.kernel_write_en) kw_cnt++;
      if (bus.res_valid && bus.res_ready) res_cnt++;
      if (bus.out_en) out_idx_q.push_back(m_out_idx);
      if (done) done_seen = 1'b1;

      acc_k    = bus.k_valid && mk;
      acc_p    = bus.pix_valid && mp;
      drain_ok = !m_out_en && (!m_res_valid || bus.res_ready);
      if (ph == P_STREAM && bus.pix_valid && !mp && m_stall < 65535) m_stall++;
      nxt_mult = acc_p ? tag(pidx) : BITS'($urandom);
      n_out    = acc_p && (pidx / W >= KS - 1) && (pidx % W >= KS - 1);
      if (m_out_en) begin
        m_res_valid = 1'b1;
        m_res_data  = m_tag;
      end else if (m_res_valid && bus.res_ready) begin
        m_res_valid = 1'b0;
      end
      if (n_out) begin
        m_tag     = tag(pidx);
        m_out_idx = pidx;
      end
      m_out_en = n_out;
      case (ph)
        P_IDLE:   if (start) begin
                    ph = reuse ? P_STREAM : P_LOAD;
                    pidx = 0; kcnt = 0; m_stall = 0;
                  end
        P_LOAD:   if (acc_k) begin
                    kcnt++;
                    if (kcnt == KS * KS) ph = P_STREAM;
                  end
        P_STREAM: if (acc_p) begin
                    if (pidx == W * H - 1) ph = P_DRAIN;
                    pidx++;
                  end
        P_DRAIN:  if (drain_ok) ph = P_DONE;
        default:  ph = P_IDLE;
      endcase
    end
  end

  // Registered multiplier stand-in: valid data only in the out_en cycle.
  initial begin
    bus.mult_result = '0;
    forever begin
      @(posedge clk);
      #1 bus.mult_result = nxt_mult;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic ru);
    kw_cnt = 0; res_cnt = 0; out_idx_q.delete(); done_seen = 1'b0;
    start = 1'b1; reuse = ru;
    tick();
    start = 1'b0; reuse = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_k_ready", bus.k_ready, ru ? 0 : 1);
    if (ru) chk("reuse_stream_pix_ready", bus.pix_ready, 1);
`ifdef CONV_CTRL_PERF_EN
    chk("stall_cleared_on_start", stall_cycles, 0);
`endif
    tick();
  endtask

  task automatic load_kernel();
    bus.k_valid = 1'b1;
    repeat (11) tick();   // two extra cycles: k_valid must be ignored once loaded
    bus.k_valid = 1'b0;
    chk("kernel_writes", kw_cnt, KS * KS);
    chk("k_ready_after_load", bus.k_ready, 0);
  endtask

  // mode 0: steady; 1: hold first result 6 cycles; 2: random with junk inputs
  task automatic stream(input int mode, input int stop_at);
    int cyc = 0;
    int hold_left = 6;
    logic [BITS-1:0] held = '0;
    while (!done_seen && cyc < 400) begin
      if (stop_at >= 0 && pidx >= stop_at) break;
      case (mode)
        0: begin bus.pix_valid = 1'b1; bus.res_ready = 1'b1; end
        1: begin
             bus.pix_valid = 1'b1;
             if (bus.res_valid && hold_left > 0) begin
               bus.res_ready = 1'b0; hold_left--;
             end else bus.res_ready = 1'b1;
           end
        default: begin
             bus.pix_valid = 1'($urandom_range(0, 1));
             bus.res_ready = 1'($urandom_range(0, 1));
             bus.k_valid   = 1'($urandom_range(0, 1));
             start         = (ph == P_STREAM && pidx < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
           end
      endcase
      @(negedge clk);
      if (mode == 1 && !bus.res_ready) begin
        if (hold_left == 5) held = bus.res_data;
        else chk("hold_res_data", bus.res_data, held);
        chk("hold_res_valid", bus.res_valid, 1);
        chk("hold_no_shift", bus.shift_write_en, 0);
      end
      tick();
      cyc++;
    end
    bus.pix_valid = 1'b0; bus.k_valid = 1'b0; start = 1'b0; bus.res_ready = 1'b1;
    if (stop_at < 0) begin
      if (!done_seen) chk("frame_timeout", 0, 1);
      chk("results_per_frame", res_cnt, NRES);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      tick();
    end
  endtask

  task automatic chk_out_list();
    int exp_idx[6] = '{12, 13, 14, 17, 18, 19};
    chk("out_en_pulses", out_idx_q.size(), 6);
    for (int i = 0; i < 6 && i < out_idx_q.size(); i++)
      chk("out_en_pixel", out_idx_q[i], exp_idx[i]);
  endtask

  initial begin
    bus.k_valid = 1'b0; bus.pix_valid = 1'b0; bus.res_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_res_data", bus.res_data, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Frame A: load kernel, steady stream
    do_start(1'b0);
    load_kernel();
    stream(0, -1);
    chk_out_list();
    chk("last_result_data", bus.res_data, tag(19));
`ifdef CONV_CTRL_PERF_EN
    chk("stall_at_done", stall_cycles, 5);
`endif

    // Frame B: reuse kernel, host backpressure on first result
    do_start(1'b1);
    chk("reuse_no_kernel_writes", kw_cnt, 0);
    stream(1, -1);
    chk_out_list();

    // Frame C: reuse kernel, random valid/ready with ignored junk inputs
    do_start(1'b1);
    stream(2, -1);
    chk_out_list();
    chk("frame_c_kernel_writes", kw_cnt, 0);

    // Frame D: reset in the middle, then a fresh full frame
    do_start(1'b0);
    load_kernel();
    stream(0, 10);
    bus.pix_valid = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_pix_ready", bus.pix_ready, 0);
    chk("async_rst_shift", bus.shift_write_en, 0);
    chk("async_rst_out_en", bus.out_en, 0);
    chk("async_rst_res_valid", bus.res_valid, 0);
    chk("async_rst_res_data", bus.res_data, 0);
    bus.pix_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    do_start(1'b0);
    load_kernel();
    stream(0, -1);
    chk_out_list();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
